// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station; RS_SIZE entries snoop the CDB, and the lowest-index ready entry is dispatched.
// Latency: an issued ready entry dispatches on the next cycle; res_valid/res_tag follow alu_cal by one cycle.
// Backpressure: full (registered state only) blocks issue; rdy_in=0 freezes state. Macro ALU_RS_CDB_FWD_EN adds same-cycle CDB forwarding at issue.
module alu_rs #(
  parameter int ROB_WIDTH = 4,
  parameter int RS_SIZE   = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 issue_valid,
  input  logic [3:0]           issue_op,
  input  logic [31:0]          issue_vj,
  input  logic [31:0]          issue_vk,
  input  logic                 issue_qj_busy,
  input  logic                 issue_qk_busy,
  input  logic [ROB_WIDTH-1:0] issue_qj,
  input  logic [ROB_WIDTH-1:0] issue_qk,
  input  logic [ROB_WIDTH-1:0] issue_dest,
  output logic                 full,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_value,
  output logic                 alu_cal,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_op,
  output logic                 res_valid,
  output logic [ROB_WIDTH-1:0] res_tag
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic                 busy;
    logic [3:0]           op;
    logic [31:0]          vj;
    logic [31:0]          vk;
    logic                 qj_busy;
    logic                 qk_busy;
    logic [ROB_WIDTH-1:0] qj;
    logic [ROB_WIDTH-1:0] qk;
    logic [ROB_WIDTH-1:0] dest;
  } entry_t;

  entry_t             ent [RS_SIZE];
  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic               has_free;
  logic               has_ready;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   disp_idx;
  logic               do_issue;
  entry_t             issue_ent;

  // Per-entry occupancy and readiness, taken from registered state only
  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy & ~ent[i].qj_busy & ~ent[i].qk_busy;
    end
  end

  assign full = &busy_vec;

  // Lowest-index free slot for issue and lowest-index ready slot for dispatch
  always_comb begin
    has_free  = 1'b0;
    free_idx  = '0;
    has_ready = 1'b0;
    disp_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_vec[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ready_vec[i]) begin
        has_ready = 1'b1;
        disp_idx  = IDX_W'(i);
      end
    end
  end

  // A slot freed by this cycle's dispatch is not visible here, so it is reused next cycle at the earliest
  assign do_issue = issue_valid & has_free & rdy_in & ~clear;
  assign alu_cal  = has_ready & rdy_in & ~clear;

  // Dispatch mux drives zeros when nothing is dispatched
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (alu_cal) begin
      alu_a  = ent[disp_idx].vj;
      alu_b  = ent[disp_idx].vk;
      alu_op = ent[disp_idx].op;
    end
  end

  // New entry image; with forwarding, a tag broadcast this same cycle is captured at issue
  always_comb begin
    issue_ent.busy    = 1'b1;
    issue_ent.op      = issue_op;
    issue_ent.vj      = issue_vj;
    issue_ent.vk      = issue_vk;
    issue_ent.qj_busy = issue_qj_busy;
    issue_ent.qk_busy = issue_qk_busy;
    issue_ent.qj      = issue_qj;
    issue_ent.qk      = issue_qk;
    issue_ent.dest    = issue_dest;
`ifdef ALU_RS_CDB_FWD_EN
    if (cdb_valid && issue_qj_busy && (issue_qj == cdb_tag)) begin
      issue_ent.vj      = cdb_value;
      issue_ent.qj_busy = 1'b0;
    end
    if (cdb_valid && issue_qk_busy && (issue_qk == cdb_tag)) begin
      issue_ent.vk      = cdb_value;
      issue_ent.qk_busy = 1'b0;
    end
`endif
  end

  // Entry state: reset, flush, CDB snoop, issue write, dispatch release and result tag tracking
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent[i] <= '0;
      end
      res_valid <= 1'b0;
      res_tag   <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          ent[i].busy <= 1'b0;
        end
        res_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (cdb_valid && ent[i].busy) begin
            if (ent[i].qj_busy && (ent[i].qj == cdb_tag)) begin
              ent[i].vj      <= cdb_value;
              ent[i].qj_busy <= 1'b0;
            end
            if (ent[i].qk_busy && (ent[i].qk == cdb_tag)) begin
              ent[i].vk      <= cdb_value;
              ent[i].qk_busy <= 1'b0;
            end
          end
        end
        // Issue targets a non-busy slot and dispatch a busy one, so they never collide
        if (do_issue) begin
          ent[free_idx] <= issue_ent;
        end
        if (alu_cal) begin
          ent[disp_idx].busy <= 1'b0;
          res_tag            <= ent[disp_idx].dest;
        end
        res_valid <= alu_cal;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios plus randomized traffic against a slot-array reference model.
// Latency: model predicts outputs from its state each cycle and advances at the clock edge.
// Backpressure: random rdy_in/clear/reset/full conditions are exercised.
module tb_alu_rs;

  localparam int RW = 4;
  localparam int RS = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear, issue_valid;
  logic [3:0]    issue_op;
  logic [31:0]   issue_vj, issue_vk;
  logic          issue_qj_busy, issue_qk_busy;
  logic [RW-1:0] issue_qj, issue_qk, issue_dest;
  logic          full;
  logic          cdb_valid;
  logic [RW-1:0] cdb_tag;
  logic [31:0]   cdb_value;
  logic          alu_cal;
  logic [31:0]   alu_a, alu_b;
  logic [3:0]    alu_op;
  logic          res_valid;
  logic [RW-1:0] res_tag;

  always #5 clk_in = ~clk_in;

  alu_rs #(.ROB_WIDTH(RW), .RS_SIZE(RS)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_dest(issue_dest),
    .full(full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_cal(alu_cal), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .res_valid(res_valid), .res_tag(res_tag)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: an array of instruction slots
  typedef struct {
    bit        busy;
    bit [3:0]  op;
    bit [31:0] vj, vk;
    bit        qjb, qkb;
    bit [3:0]  qj, qk, dest;
  } slot_t;

  slot_t   m [RS];
  bit      m_rv;
  bit [3:0] m_rt;

  function automatic int first_ready();
    for (int i = 0; i < RS; i++)
      if (m[i].busy && !m[i].qjb && !m[i].qkb) return i;
    return -1;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < RS; i++)
      if (!m[i].busy) return i;
    return -1;
  endfunction

  // Check outputs mid-cycle against the model, then advance the model through the edge
  task automatic cycle();
    int    d, f;
    bit    cal;
    slot_t n;
    @(negedge clk_in);
    d   = first_ready();
    f   = first_free();
    cal = (d >= 0) && rdy_in && !clear;
    check("full", full, (f < 0));
    check("alu_cal", alu_cal, cal);
    check("alu_a", alu_a, cal ? m[d].vj : 32'd0);
    check("alu_b", alu_b, cal ? m[d].vk : 32'd0);
    check("alu_op", alu_op, cal ? m[d].op : 4'd0);
    check("res_valid", res_valid, m_rv);
    check("res_tag", res_tag, m_rt);
    if (!rst_in) begin
      for (int i = 0; i < RS; i++) m[i].busy = 0;
      m_rv = 0;
      m_rt = 0;
    end else if (rdy_in) begin
      if (clear) begin
        for (int i = 0; i < RS; i++) m[i].busy = 0;
        m_rv = 0;
      end else begin
        if (cdb_valid)
          for (int i = 0; i < RS; i++) begin
            if (m[i].busy && m[i].qjb && m[i].qj == cdb_tag) begin m[i].vj = cdb_value; m[i].qjb = 0; end
            if (m[i].busy && m[i].qkb && m[i].qk == cdb_tag) begin m[i].vk = cdb_value; m[i].qkb = 0; end
          end
        if (cal) begin
          m_rt = m[d].dest;
          m[d].busy = 0;
        end
        m_rv = cal;
        if (issue_valid && f >= 0) begin
          n = '{1'b1, issue_op, issue_vj, issue_vk, issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_dest};
`ifdef ALU_RS_CDB_FWD_EN
          if (cdb_valid && n.qjb && n.qj == cdb_tag) begin n.vj = cdb_value; n.qjb = 0; end
          if (cdb_valid && n.qkb && n.qk == cdb_tag) begin n.vk = cdb_value; n.qkb = 0; end
`endif
          m[f] = n;
        end
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    clear = 0; issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0;
    issue_qj_busy = 0; issue_qk_busy = 0; issue_qj = 0; issue_qk = 0; issue_dest = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
  endtask

  task automatic put(input bit [3:0] op, input bit [31:0] vj, input bit [31:0] vk,
                     input bit qjb, input bit [3:0] qj, input bit [3:0] dest);
    issue_valid = 1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = qjb; issue_qj = qj; issue_qk_busy = 0; issue_qk = 0; issue_dest = dest;
  endtask

  initial begin
    for (int i = 0; i < RS; i++) m[i] = '{default: 0};
    m_rv = 0; m_rt = 0;
    rst_in = 0; rdy_in = 1; idle();
    #1;
    cycle(); cycle();
    check("rst_full", full, 0);
    check("rst_cal", alu_cal, 0);
    check("rst_res_valid", res_valid, 0);
    rst_in = 1;

    // Both operands ready: dispatch next cycle, result tag the cycle after
    put(4'd0, 32'd5, 32'd7, 0, 0, 4'd9);
    cycle(); idle(); #3;
    check("t1_cal", alu_cal, 1);
    check("t1_a", alu_a, 5);
    check("t1_b", alu_b, 7);
    cycle(); #3;
    check("t1_res_valid", res_valid, 1);
    check("t1_res_tag", res_tag, 9);
    cycle();

    // Operand j waits for tag 3, delivered two cycles later
    put(4'd1, 32'd0, 32'd2, 1, 4'd3, 4'd4);
    cycle(); idle(); cycle();
    cdb_valid = 1; cdb_tag = 3; cdb_value = 10; #3;
    check("t2_cal_before", alu_cal, 0);
    cycle(); idle(); #3;
    check("t2_cal", alu_cal, 1);
    check("t2_a", alu_a, 10);
    check("t2_b", alu_b, 2);
    cycle(); cycle();

    // Fill with four waiting entries, reject a fifth, wake entry 2
    for (int i = 0; i < 4; i++) begin
      put(4'(i), 32'h0, 32'h200 + i, 1, 4'(i + 1), 4'(i + 8));
      cycle();
    end
    #3 check("t3_full", full, 1);
    put(4'd2, 32'd1, 32'd1, 0, 0, 4'hF);
    cycle(); idle(); #3;
    check("t3_full_after_reject", full, 1);
    check("t3_cal_after_reject", alu_cal, 0);
    cdb_valid = 1; cdb_tag = 3; cdb_value = 32'h33;
    cycle(); idle(); #3;
    check("t3_cal", alu_cal, 1);
    check("t3_a", alu_a, 32'h33);
    check("t3_b", alu_b, 32'h202);
    cycle(); #3;
    check("t3_full_freed", full, 0);
    check("t3_res_valid", res_valid, 1);

    // Flush with three busy entries and a result in flight
    clear = 1;
    cycle(); idle(); #3;
    check("t4_full", full, 0);
    check("t4_cal", alu_cal, 0);
    check("t4_res_valid", res_valid, 0);

    // Entries 1 and 3 woken together: 1 goes first, 3 next
    for (int i = 0; i < 4; i++) begin
      put(4'd3, 32'h0, 32'h100 + i, 1, (i % 2 == 1) ? 4'd5 : 4'(i + 10), 4'(i));
      cycle();
    end
    idle(); cdb_valid = 1; cdb_tag = 5; cdb_value = 32'h55;
    cycle(); idle(); #3;
    check("t5_first", alu_b, 32'h101);
    cycle(); #3;
    check("t5_second", alu_b, 32'h103);
    check("t5_second_tag", res_tag, 1);
    clear = 1; cycle(); idle();

    // rdy_in low holds everything even with a ready entry and traffic on the inputs
    put(4'd6, 32'h77, 32'h88, 0, 0, 4'd6);
    cycle(); idle();
    rdy_in = 0; put(4'd7, 32'h1, 32'h1, 0, 0, 4'd7); cdb_valid = 1; clear = 1; #3;
    check("t6_cal_frozen", alu_cal, 0);
    cycle(); cycle(); idle(); rdy_in = 1; #3;
    check("t6_cal_resume", alu_cal, 1);
    check("t6_a_resume", alu_a, 32'h77);
    cycle(); cycle();

`ifdef ALU_RS_CDB_FWD_EN
    // Same-cycle CDB forwarding at issue
    put(4'd2, 32'h0, 32'd3, 1, 4'd6, 4'd2);
    cdb_valid = 1; cdb_tag = 6; cdb_value = 9;
    cycle(); idle(); #3;
    check("t7_fwd_cal", alu_cal, 1);
    check("t7_fwd_a", alu_a, 9);
    cycle(); cycle();
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst_in = ($urandom_range(0, 299) != 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 39) == 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_op = 4'($urandom_range(0, 14));
      issue_vj = $urandom; issue_vk = $urandom;
      issue_qj_busy = $urandom_range(0, 1); issue_qk_busy = $urandom_range(0, 1);
      issue_qj = 4'($urandom); issue_qk = 4'($urandom); issue_dest = 4'($urandom);
      cdb_valid = $urandom_range(0, 1); cdb_tag = 4'($urandom); cdb_value = $urandom;
`ifndef ALU_RS_CDB_FWD_EN
      if (issue_valid && ((issue_qj_busy && issue_qj == cdb_tag) || (issue_qk_busy && issue_qk == cdb_tag)))
        cdb_valid = 0;
`endif
      cycle();
    end

    // Reset in the middle of activity discards everything
    idle(); rst_in = 1; rdy_in = 1;
    for (int i = 0; i < 3; i++) begin
      put(4'd1, 32'd1, 32'd1, (i != 0), 4'(i), 4'(i + 3));
      cycle();
    end
    idle(); rst_in = 0; cdb_valid = 1;
    cycle(); idle(); rst_in = 1; #3;
    check("t8_full", full, 0);
    check("t8_cal", alu_cal, 0);
    check("t8_res_valid", res_valid, 0);
    check("t8_res_tag", res_tag, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter ROB_WIDTH, default 4: width of ROB tags.
REQ-002 Parameter RS_SIZE, default 4: number of station entries, 2..16.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-low.
REQ-005 rdy_in  input  1  global enable; 0 freezes all state.
REQ-006 clear  input  1  pipeline flush on mispredict; qualified by rdy_in.
REQ-007 issue_valid  input  1  new instruction offered this cycle.
REQ-008 issue_op  input  4  ALU opcode (ALU encoding 0000..1110).
REQ-009 issue_vj, issue_vk  input  32 each  operand values when ready.
REQ-010 issue_qj_busy, issue_qk_busy  input  1 each  operand still awaits a tag.
REQ-011 issue_qj, issue_qk  input  ROB_WIDTH each  awaited producer tags.
REQ-012 issue_dest  input  ROB_WIDTH  ROB tag of the instruction.
REQ-013 full  output  1  no free entry; issue ignored while high.
REQ-014 cdb_valid, cdb_tag[ROB_WIDTH], cdb_value[32]  input  common data bus snoop.
REQ-015 alu_cal  output  1  dispatch strobe to ALU.
REQ-016 alu_a, alu_b  output  32 each; alu_op  output  4  dispatched operands/opcode.
REQ-017 res_valid  output  1; res_tag  output  ROB_WIDTH  ALU result in flight is valid/owned by tag.

Function
REQ-018 Entry: busy, op, vj, vk, qj_busy, qk_busy, qj, qk, dest; ready = busy & !qj_busy & !qk_busy.
REQ-019 full = all entries busy, from registered state only.
REQ-020 Issue when issue_valid & !full & rdy_in & !clear: write lowest-index non-busy entry, busy=1.
REQ-021 issue_valid while full: ignored, no state change.
REQ-022 Snoop: each cycle with cdb_valid, every busy entry with q?_busy and q?==cdb_tag captures cdb_value into v?, clears q?_busy.
REQ-023 Entry woken by CDB in cycle t is dispatchable no earlier than cycle t+1.
REQ-024 Dispatch combinational from registered state: alu_cal=1 iff a ready entry exists and rdy_in & !clear; alu_a/alu_b/alu_op from lowest-index ready entry; 0 otherwise.
REQ-025 On dispatch edge: entry busy cleared; res_valid<=1, res_tag<=entry dest; else res_valid<=0.
REQ-026 Result latency: res_valid/res_tag assert exactly 1 cycle after alu_cal, aligned with ALU registered result.
REQ-027 Dispatch and issue in same cycle allowed; freed entry reallocatable no earlier than next cycle.
REQ-028 At most one issue and one dispatch per cycle.
REQ-029 clear (with rdy_in): all busy<=0, res_valid<=0; overrides issue, snoop, dispatch same cycle.
REQ-030 rdy_in=0: no state update, alu_cal=0, res_valid/res_tag hold.

Reset
REQ-031 rst_in=0 at edge: all busy<=0, res_valid<=0, res_tag<=0; full=0, alu_cal=0, alu_a/alu_b/alu_op=0.
REQ-032 Reset overrides rdy_in, clear, issue; reset asserted mid-operation discards all entries and in-flight result.

Configuration
REQ-033 Macro ALU_RS_CDB_FWD_EN defined: issuing operand whose tag equals same-cycle cdb_tag (cdb_valid=1) stored with value cdb_value, q?_busy=0.
REQ-034 Macro undefined: issue fields stored verbatim; issue side guarantees no same-cycle tag match.

Verification
REQ-035 Reset, issue op=0000 vj=5 vk=7 both ready -> next cycle alu_cal=1 a=5 b=7; following cycle res_valid=1 res_tag=issue_dest.
REQ-036 Issue qj_busy qj=3, vk=2; 2 cycles later cdb tag=3 value=10 -> alu_cal cycle after CDB with a=10 b=2.
REQ-037 Issue 4 non-ready entries -> full=1; 5th issue ignored; wake entry 2 -> dispatched, full=0 next cycle.
REQ-038 Entries 1 and 3 ready same cycle -> entry 1 dispatched first, entry 3 next cycle.
REQ-039 clear with 3 busy entries and res_valid=1 -> next cycle full=0, alu_cal=0, res_valid=0.
REQ-040 With ALU_RS_CDB_FWD_EN: issue qj=6 same cycle as cdb tag=6 value=9 -> dispatch next cycle a=9; rdy_in=0 for 2 cycles -> alu_cal=0, state unchanged.
